// File: rtl/lsu_exc_pipe.sv
// LSU exception pipe: carries dc1 fault results through dc2/dc3, raises a prioritised
// load/store exception at dc3, and keeps a sticky trap value plus a saturating fault counter.
module lsu_exc_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             freeze,
  input  logic             flush_dc2,
  input  logic             flush_dc3,
  input  logic             valid_dc1,
  input  logic             store_dc1,
  input  logic             dma_dc1,
  input  logic [31:0]      addr_dc1,
  input  logic             access_fault_dc1,
  input  logic             misaligned_fault_dc1,
  output logic             exc_valid_dc3,
  output logic [3:0]       exc_cause_dc3,
  output logic [31:0]      exc_addr_dc3,
  input  logic             trap_ack,
  output logic             mtval_valid,
  output logic [31:0]      mtval,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] fault_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Misaligned outranks access fault; store causes sit two above the load causes.
  function automatic logic [3:0] exc_cause(input logic st, input logic mis);
    logic [3:0] c;
    c = mis ? 4'd4 : 4'd5;
    return st ? c + 4'd2 : c;
  endfunction

  logic        vld_dc2_q, st_dc2_q, acc_dc2_q, mis_dc2_q;
  logic [31:0] addr_dc2_q;
  logic        vld_dc3_q, st_dc3_q, acc_dc3_q, mis_dc3_q;
  logic [31:0] addr_dc3_q;
  logic        vld_dc2_d, st_dc2_d, acc_dc2_d, mis_dc2_d;
  logic [31:0] addr_dc2_d;
  logic        vld_dc3_d, st_dc3_d, acc_dc3_d, mis_dc3_d;
  logic [31:0] addr_dc3_d;
  logic        mtval_valid_q, mtval_valid_d;
  logic [31:0] mtval_q, mtval_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        deliver;

  assign exc_valid_dc3 = vld_dc3_q & (acc_dc3_q | mis_dc3_q) & ~flush_dc3;
  assign exc_cause_dc3 = exc_valid_dc3 ? exc_cause(st_dc3_q, mis_dc3_q) : 4'd0;
  assign exc_addr_dc3  = exc_valid_dc3 ? addr_dc3_q : 32'd0;
  assign deliver       = exc_valid_dc3 & ~freeze;
  assign mtval_valid   = mtval_valid_q;
  assign mtval         = mtval_q;
  assign fault_cnt     = cnt_q;

  always_comb begin
    vld_dc2_d  = vld_dc2_q;
    st_dc2_d   = st_dc2_q;
    acc_dc2_d  = acc_dc2_q;
    mis_dc2_d  = mis_dc2_q;
    addr_dc2_d = addr_dc2_q;
    vld_dc3_d  = vld_dc3_q;
    st_dc3_d   = st_dc3_q;
    acc_dc3_d  = acc_dc3_q;
    mis_dc3_d  = mis_dc3_q;
    addr_dc3_d = addr_dc3_q;
    if (!freeze) begin
      // dc1 -> dc2: DMA accesses never fault
      vld_dc2_d  = valid_dc1;
      st_dc2_d   = store_dc1;
      acc_dc2_d  = access_fault_dc1 & ~dma_dc1;
      mis_dc2_d  = misaligned_fault_dc1 & ~dma_dc1;
      addr_dc2_d = addr_dc1;
      // dc2 -> dc3: an entry in dc3 is always replaced, so flush_dc3 needs no state
      vld_dc3_d  = vld_dc2_q & ~flush_dc2;
      st_dc3_d   = st_dc2_q;
      acc_dc3_d  = acc_dc2_q;
      mis_dc3_d  = mis_dc2_q;
      addr_dc3_d = addr_dc2_q;
    end
  end

  always_comb begin
    mtval_valid_d = mtval_valid_q;
    mtval_d       = mtval_q;
    cnt_d         = cnt_q;
    if (deliver && (!mtval_valid_q || trap_ack)) begin
      mtval_d       = exc_addr_dc3;
      mtval_valid_d = 1'b1;
    end else if (trap_ack) begin
      mtval_valid_d = 1'b0;
    end
    if (cnt_clr)      cnt_d = '0;
    else if (deliver) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      vld_dc2_q     <= 1'b0;
      st_dc2_q      <= 1'b0;
      acc_dc2_q     <= 1'b0;
      mis_dc2_q     <= 1'b0;
      addr_dc2_q    <= 32'd0;
      vld_dc3_q     <= 1'b0;
      st_dc3_q      <= 1'b0;
      acc_dc3_q     <= 1'b0;
      mis_dc3_q     <= 1'b0;
      addr_dc3_q    <= 32'd0;
      mtval_valid_q <= 1'b0;
      mtval_q       <= 32'd0;
      cnt_q         <= '0;
    end else begin
      vld_dc2_q     <= vld_dc2_d;
      st_dc2_q      <= st_dc2_d;
      acc_dc2_q     <= acc_dc2_d;
      mis_dc2_q     <= mis_dc2_d;
      addr_dc2_q    <= addr_dc2_d;
      vld_dc3_q     <= vld_dc3_d;
      st_dc3_q      <= st_dc3_d;
      acc_dc3_q     <= acc_dc3_d;
      mis_dc3_q     <= mis_dc3_d;
      addr_dc3_q    <= addr_dc3_d;
      mtval_valid_q <= mtval_valid_d;
      mtval_q       <= mtval_d;
      cnt_q         <= cnt_d;
    end
  end

endmodule

// File: tb/tb_lsu_exc_pipe.sv
// Directed bench for lsu_exc_pipe: hand-computed expectations checked with immediate assertions.
module tb_lsu_exc_pipe;

  logic        clk = 1'b0;
  logic        rst_l, freeze, flush_dc2, flush_dc3;
  logic        valid_dc1, store_dc1, dma_dc1;
  logic [31:0] addr_dc1;
  logic        access_fault_dc1, misaligned_fault_dc1;
  logic        exc_valid_dc3;
  logic [3:0]  exc_cause_dc3;
  logic [31:0] exc_addr_dc3;
  logic        trap_ack, mtval_valid;
  logic [31:0] mtval;
  logic        cnt_clr;
  logic [15:0] fault_cnt;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  lsu_exc_pipe #(.CNT_W(16)) dut (
    .clk(clk), .rst_l(rst_l), .freeze(freeze), .flush_dc2(flush_dc2), .flush_dc3(flush_dc3),
    .valid_dc1(valid_dc1), .store_dc1(store_dc1), .dma_dc1(dma_dc1), .addr_dc1(addr_dc1),
    .access_fault_dc1(access_fault_dc1), .misaligned_fault_dc1(misaligned_fault_dc1),
    .exc_valid_dc3(exc_valid_dc3), .exc_cause_dc3(exc_cause_dc3), .exc_addr_dc3(exc_addr_dc3),
    .trap_ack(trap_ack), .mtval_valid(mtval_valid), .mtval(mtval),
    .cnt_clr(cnt_clr), .fault_cnt(fault_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input logic st, input logic dma, input logic [31:0] a,
                       input logic acc, input logic mis);
    valid_dc1 = v; store_dc1 = st; dma_dc1 = dma; addr_dc1 = a;
    access_fault_dc1 = acc; misaligned_fault_dc1 = mis;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_l = 1'b0; freeze = 1'b0; flush_dc2 = 1'b0; flush_dc3 = 1'b0;
    trap_ack = 1'b0; cnt_clr = 1'b0;
    idle();
    step(2);
    chk("rst_exc_valid", exc_valid_dc3, 0);
    chk("rst_cause", exc_cause_dc3, 0);
    chk("rst_addr", exc_addr_dc3, 0);
    chk("rst_mtval_valid", mtval_valid, 0);
    chk("rst_mtval", mtval, 0);
    chk("rst_cnt", fault_cnt, 0);
    rst_l = 1'b1;
    step();

    // Load access fault, two-cycle latency
    drive(1'b1, 1'b0, 1'b0, 32'h0000_1002, 1'b1, 1'b0);
    step(); idle();
    step();
    chk("ld_acc_valid", exc_valid_dc3, 1);
    chk("ld_acc_cause", exc_cause_dc3, 5);
    chk("ld_acc_addr", exc_addr_dc3, 32'h0000_1002);
    step();
    chk("ld_acc_mtval", mtval, 32'h0000_1002);
    chk("ld_acc_mtval_valid", mtval_valid, 1);
    chk("ld_acc_cnt", fault_cnt, 1);
    chk("ld_acc_gone", exc_valid_dc3, 0);
    trap_ack = 1'b1; step(); trap_ack = 1'b0;
    chk("ack_clears", mtval_valid, 0);
    chk("ack_keeps_mtval", mtval, 32'h0000_1002);

    // Store with both faults, frozen for three edges at dc3
    drive(1'b1, 1'b1, 1'b0, 32'h2000_0001, 1'b1, 1'b1);
    step(); idle();
    step();
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("frz_valid", exc_valid_dc3, 1);
      chk("frz_cause", exc_cause_dc3, 6);
      chk("frz_cnt", fault_cnt, 1);
      step();
    end
    freeze = 1'b0;
    chk("frz_rel_valid", exc_valid_dc3, 1);
    chk("frz_rel_mtval_valid", mtval_valid, 0);
    step();
    chk("frz_cnt_once", fault_cnt, 2);
    chk("frz_mtval", mtval, 32'h2000_0001);
    chk("frz_done", exc_valid_dc3, 0);
    step();
    chk("frz_cnt_stable", fault_cnt, 2);
    trap_ack = 1'b1; step(); trap_ack = 1'b0;

    // Back-to-back faulting loads: first fault wins the sticky value
    drive(1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 1'b0);
    step(); idle();
    chk("b2b_first_addr", exc_addr_dc3, 32'h10);
    step();
    chk("b2b_second_addr", exc_addr_dc3, 32'h20);
    step();
    chk("b2b_mtval", mtval, 32'h10);
    chk("b2b_cnt", fault_cnt, 4);
    drive(1'b1, 1'b0, 1'b0, 32'h30, 1'b1, 1'b0);
    step(); idle();
    step();
    trap_ack = 1'b1;
    step(); trap_ack = 1'b0;
    chk("ack_deliver_mtval", mtval, 32'h30);
    chk("ack_deliver_valid", mtval_valid, 1);
    chk("ack_deliver_cnt", fault_cnt, 5);

    // flush_dc2 and flush_dc3 kill faulting loads
    drive(1'b1, 1'b0, 1'b0, 32'h40, 1'b1, 1'b0);
    step(); idle();
    flush_dc2 = 1'b1;
    step(); flush_dc2 = 1'b0;
    chk("fl2_valid", exc_valid_dc3, 0);
    step();
    chk("fl2_cnt", fault_cnt, 5);
    drive(1'b1, 1'b0, 1'b0, 32'h50, 1'b1, 1'b0);
    step(); idle();
    step();
    flush_dc3 = 1'b1;
    #1;
    chk("fl3_valid", exc_valid_dc3, 0);
    chk("fl3_cause", exc_cause_dc3, 0);
    chk("fl3_addr", exc_addr_dc3, 0);
    step(); flush_dc3 = 1'b0;
    chk("fl3_cnt", fault_cnt, 5);
    chk("fl3_mtval", mtval, 32'h30);
    chk("fl3_mtval_valid", mtval_valid, 1);

    // DMA with an access fault flows through silently
    drive(1'b1, 1'b0, 1'b1, 32'h60, 1'b1, 1'b1);
    step(); idle();
    step();
    chk("dma_valid", exc_valid_dc3, 0);
    step();
    chk("dma_cnt", fault_cnt, 5);

    // Remaining cause codes
    drive(1'b1, 1'b0, 1'b0, 32'hA0, 1'b0, 1'b1);
    step();
    drive(1'b1, 1'b1, 1'b0, 32'hB0, 1'b1, 1'b0);
    step(); idle();
    chk("ld_mis_cause", exc_cause_dc3, 4);
    step();
    chk("st_acc_cause", exc_cause_dc3, 7);
    chk("st_acc_addr", exc_addr_dc3, 32'hB0);
    step();
    chk("cause_cnt", fault_cnt, 7);

    // Reset with a fault in flight
    drive(1'b1, 1'b0, 1'b0, 32'h70, 1'b1, 1'b0);
    step(); idle();
    rst_l = 1'b0;
    step();
    chk("mrst_exc_valid", exc_valid_dc3, 0);
    chk("mrst_mtval_valid", mtval_valid, 0);
    chk("mrst_mtval", mtval, 0);
    chk("mrst_cnt", fault_cnt, 0);
    rst_l = 1'b1;
    step();
    chk("mrst_no_emerge", exc_valid_dc3, 0);
    step();
    chk("mrst_cnt_after", fault_cnt, 0);

    // Saturation: stream faults every cycle; deliveries begin on the third edge
    drive(1'b1, 1'b0, 1'b0, 32'h80, 1'b1, 1'b0);
    step(65536);
    chk("sat_below", fault_cnt, 16'hFFFE);
    step();
    chk("sat_reach", fault_cnt, 16'hFFFF);
    step();
    chk("sat_hold", fault_cnt, 16'hFFFF);
    chk("sat_stream_valid", exc_valid_dc3, 1);
    cnt_clr = 1'b1;
    step(); cnt_clr = 1'b0;
    chk("clr_priority", fault_cnt, 0);
    step();
    chk("clr_then_count", fault_cnt, 1);
    idle();
    step(3);
    chk("sat_mtval", mtval, 32'h80);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
